muldiv_unit: RTL and testbench
==============================

Name: muldiv_unit

Overview:
- Parametrised, iterative RV M-extension execute unit: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU.
- Sits beside the combinational ALU in the execute stage. It takes operands and the funct3 code from decode/execute and returns one XLEN-bit result.
- Uses a valid/ready handshake so the pipeline stalls while an operation is in flight.
- Radix-2: one bit per cycle, with a single-cycle fast path for the divide special cases.

Parameters:
- XLEN, 32, operand/result width; legal values are even and >= 8.
- CNT_W, $clog2(XLEN+1), iteration counter width; derived, not overridden.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  operation request.
- in_ready  out  1  unit can accept; high only in IDLE.
- in_func  in  3  M-ext funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- in_op1  in  XLEN  rs1 value (multiplicand / dividend).
- in_op2  in  XLEN  rs2 value (multiplier / divisor).
- flush  in  1  pipeline kill; abandons the current operation.
- out_valid  out  1  result available; high only in DONE.
- out_ready  in  1  consumer takes the result.
- out_result  out  XLEN  result.

Behaviour:
- Reset, synchronous and active-high: state=IDLE, in_ready=1, out_valid=0, out_result=0, counter=0. Reset mid-operation abandons the operation and produces no output.
- FSM has three states: IDLE, CALC, DONE.
  - IDLE: in_ready=1. On in_valid && !flush, latch func and operands.
    - Divide special case: go directly to DONE (fast path).
    - Otherwise: go to CALC with counter=XLEN.
  - CALC: one iteration per cycle, counter decrements. When the counter reaches 1, the final sign-corrected result is registered and the FSM goes to DONE.
  - DONE: out_valid=1. out_result is held stable until out_ready. On out_ready, go to IDLE.
- flush: from any state, go to IDLE on the next edge, with out_valid=0.
  - flush beats in_valid in the same cycle: no accept.
  - flush beats out_ready in DONE: the result is dropped.
- Latency, with the accept edge as cycle 0:
  - Normal ops: out_valid first high at cycle XLEN+1 (33 for XLEN=32).
  - Fast path: out_valid first high at cycle 1.
  - Next accept is possible no earlier than the cycle after the out_ready handshake, since in_ready is low in CALC and DONE.
- Signedness:
  - Signed operands are MULH (both), MULHSU (op1 only), DIV and REM (both).
  - Operands are converted to magnitudes at accept; the result sign is stored.
- Multiply: shift-add over the XLEN-bit magnitudes into a 2*XLEN-bit product. Negate if signs differ.
  - MUL returns product[XLEN-1:0].
  - The MULH variants return product[2*XLEN-1:XLEN].
- Divide: restoring division on magnitudes.
  - Quotient is negated if the operand signs differ.
  - Remainder takes the dividend's sign.
  - Division truncates toward zero.
- Divide special cases (fast path):
  - Divide by zero: DIV/DIVU return all ones; REM/REMU return op1.
  - Signed overflow, op1 = 1<<(XLEN-1) and op2 = all ones, DIV/REM only: DIV returns op1, REM returns 0.
- No exceptions are raised. Operand inputs are don't-care when not accepted.

Decomposition:
- Shared package riscv_pkg:
  - M-ext funct3 localparams (FUNC_MUL ... FUNC_REMU), alongside the existing ALU funct3 constants.
  - FSM state encodings (ST_IDLE, ST_CALC, ST_DONE).
- One natural sub-module, muldiv_iter. It is the combinational single-step datapath: add-or-pass for multiply, subtract-and-restore for divide, on {acc, operand} registers.
- muldiv_unit owns the FSM, counter, sign handling and handshake.

Test Plan:
- MUL 7 x 0xFFFFFFFD: out_result=0xFFFFFFEB; out_valid exactly 33 cycles after accept; in_ready low throughout.
- High products:
  - MULH 0x80000000 x 0x80000000 -> 0x40000000.
  - MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE.
  - MULHSU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF.
- Division results:
  - DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD.
  - REM same operands -> 0xFFFFFFFF.
  - DIVU 100 / 7 -> 14.
  - REMU 100 / 7 -> 2.
- Fast path, each with out_valid at cycle 1:
  - DIV 5/0 -> 0xFFFFFFFF; REMU 5/0 -> 5.
  - DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM same operands -> 0.
- Backpressure: hold out_ready=0 for 5 cycles in DONE. Result must stay stable and in_ready stay 0. Raise out_ready, then present a new op: it is accepted the following cycle.
- Flush and reset:
  - Assert flush at cycle 10 of a DIV: out_valid never rises and in_ready=1 the next cycle.
  - Assert flush together with in_valid in IDLE: no accept.
  - Repeat both with reset instead of flush: same outcome.
  - Rerun all cases with XLEN=16: MUL 0x00FF x 0x0101 -> 0xFFFF, out_valid at cycle 17.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RISC-V execute-stage constants: ALU and M-extension funct3 codes,
// muldiv FSM state encodings and operand signedness helpers.
package riscv_pkg;

  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_SLL  = 3'b001;
  localparam logic [2:0] ALU_SLT  = 3'b010;
  localparam logic [2:0] ALU_SLTU = 3'b011;
  localparam logic [2:0] ALU_XOR  = 3'b100;
  localparam logic [2:0] ALU_SR   = 3'b101;
  localparam logic [2:0] ALU_OR   = 3'b110;
  localparam logic [2:0] ALU_AND  = 3'b111;

  localparam logic [2:0] FUNC_MUL    = 3'b000;
  localparam logic [2:0] FUNC_MULH   = 3'b001;
  localparam logic [2:0] FUNC_MULHSU = 3'b010;
  localparam logic [2:0] FUNC_MULHU  = 3'b011;
  localparam logic [2:0] FUNC_DIV    = 3'b100;
  localparam logic [2:0] FUNC_DIVU   = 3'b101;
  localparam logic [2:0] FUNC_REM    = 3'b110;
  localparam logic [2:0] FUNC_REMU   = 3'b111;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  function automatic logic op1_is_signed(input logic [2:0] func);
    return (func == FUNC_MULH) || (func == FUNC_MULHSU) ||
           (func == FUNC_DIV)  || (func == FUNC_REM);
  endfunction

  function automatic logic op2_is_signed(input logic [2:0] func);
    return (func == FUNC_MULH) || (func == FUNC_DIV) || (func == FUNC_REM);
  endfunction

endpackage

// File: rtl/muldiv_iter.sv
// One radix-2 step on the {acc, opr} register pair: shift-add for multiply,
// shift-subtract-restore for divide. Purely combinational.
module muldiv_iter #(
  parameter int XLEN = 32
) (
  input  logic            is_div,
  input  logic [XLEN-1:0] acc,
  input  logic [XLEN-1:0] opr,
  input  logic [XLEN-1:0] mcand,
  output logic [XLEN-1:0] acc_next,
  output logic [XLEN-1:0] opr_next
);

  logic [XLEN:0] sum;
  logic [XLEN:0] rem_sh;
  logic [XLEN:0] diff;

  // Divide keeps acc below the divisor, so the top bit of diff is a clean borrow flag.
  always_comb begin
    sum    = {1'b0, acc} + (opr[0] ? {1'b0, mcand} : '0);
    rem_sh = {acc, opr[XLEN-1]};
    diff   = rem_sh - {1'b0, mcand};
    if (is_div) begin
      if (!diff[XLEN]) begin
        acc_next = diff[XLEN-1:0];
        opr_next = {opr[XLEN-2:0], 1'b1};
      end else begin
        acc_next = rem_sh[XLEN-1:0];
        opr_next = {opr[XLEN-2:0], 1'b0};
      end
    end else begin
      acc_next = sum[XLEN:1];
      opr_next = {sum[0], opr[XLEN-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV M-extension multiply/divide unit with valid/ready handshake,
// one bit per cycle plus a single-cycle path for divide special cases.
module muldiv_unit
  import riscv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      in_func,
  input  logic [XLEN-1:0] in_op1,
  input  logic [XLEN-1:0] in_op2,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_result
);

  localparam int CNT_W = $clog2(XLEN + 1);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  logic [1:0]       state_q, state_d;
  logic [2:0]       func_q, func_d;
  logic             neg_q, neg_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0]  acc_q, acc_d;
  logic [XLEN-1:0]  opr_q, opr_d;
  logic [XLEN-1:0]  mcand_q, mcand_d;
  logic [XLEN-1:0]  result_q, result_d;

  logic              neg1, neg2, div_zero, div_ovf, accept;
  logic [XLEN-1:0]   mag1, mag2, fast_result, final_result;
  logic [XLEN-1:0]   acc_step, opr_step, quo, rem;
  logic [2*XLEN-1:0] prod, prod_signed;

  muldiv_iter #(.XLEN(XLEN)) u_iter (
    .is_div   (func_q[2]),
    .acc      (acc_q),
    .opr      (opr_q),
    .mcand    (mcand_q),
    .acc_next (acc_step),
    .opr_next (opr_step)
  );

  // Operands become magnitudes at accept; the special divide cases are decided here too.
  always_comb begin
    accept      = in_valid && !flush;
    neg1        = op1_is_signed(in_func) && in_op1[XLEN-1];
    neg2        = op2_is_signed(in_func) && in_op2[XLEN-1];
    mag1        = neg1 ? -in_op1 : in_op1;
    mag2        = neg2 ? -in_op2 : in_op2;
    div_zero    = (in_op2 == '0);
    div_ovf     = !in_func[0] && (in_op1 == MIN_NEG) && (in_op2 == '1);
    fast_result = '0;
    if (div_zero) fast_result = in_func[1] ? in_op1 : '1;
    else if (div_ovf) fast_result = in_func[1] ? '0 : in_op1;
  end

  // The last step's outputs feed straight into sign correction so DONE sees a final value.
  always_comb begin
    prod        = {acc_step, opr_step};
    prod_signed = neg_q ? -prod : prod;
    quo         = neg_q ? -opr_step : opr_step;
    rem         = neg_q ? -acc_step : acc_step;
    case (func_q)
      FUNC_MUL:               final_result = prod_signed[XLEN-1:0];
      FUNC_DIV, FUNC_DIVU:    final_result = quo;
      FUNC_REM, FUNC_REMU:    final_result = rem;
      default:                final_result = prod_signed[2*XLEN-1:XLEN];
    endcase
  end

  always_comb begin
    state_d  = state_q;
    func_d   = func_q;
    neg_d    = neg_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    opr_d    = opr_q;
    mcand_d  = mcand_q;
    result_d = result_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          func_d = in_func;
          acc_d  = '0;
          cnt_d  = CNT_W'(XLEN);
          if (in_func[2]) begin
            opr_d   = mag1;
            mcand_d = mag2;
            neg_d   = in_func[1] ? neg1 : (neg1 ^ neg2);
            if (div_zero || div_ovf) begin
              state_d  = ST_DONE;
              result_d = fast_result;
            end else begin
              state_d = ST_CALC;
            end
          end else begin
            opr_d   = mag2;
            mcand_d = mag1;
            neg_d   = neg1 ^ neg2;
            state_d = ST_CALC;
          end
        end
      end
      ST_CALC: begin
        acc_d = acc_step;
        opr_d = opr_step;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d  = ST_DONE;
          result_d = final_result;
        end
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (flush) state_d = ST_IDLE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      func_q   <= '0;
      neg_q    <= 1'b0;
      cnt_q    <= '0;
      acc_q    <= '0;
      opr_q    <= '0;
      mcand_q  <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      func_q   <= func_d;
      neg_q    <= neg_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      opr_q    <= opr_d;
      mcand_q  <= mcand_d;
      result_q <= result_d;
    end
  end

  assign in_ready   = (state_q == ST_IDLE);
  assign out_valid  = (state_q == ST_DONE);
  assign out_result = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit at XLEN=32 and XLEN=16 against an
// arithmetic reference model of the M-extension semantics.
module tb_muldiv_unit;
  import riscv_pkg::*;

  typedef struct {
    logic [2:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } case_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_all, sel16, in_valid, flush, reset, out_ready;
  logic [2:0]  in_func;
  logic [31:0] in_op1, in_op2;
  logic        rst32, rst16, v32, v16, fl32, fl16, ordy32, ordy16;
  logic        rdy32, rdy16, ov32, ov16;
  logic [31:0] res32;
  logic [15:0] res16;
  logic        obs_ready, obs_valid;
  logic [31:0] obs_result;
  int          total = 0;
  int          bad = 0;
  int          cur_w = 32;

  // Drive only the DUT currently under test; the other one sits idle.
  assign rst32  = reset_all | (reset & ~sel16);
  assign rst16  = reset_all | (reset & sel16);
  assign v32    = in_valid & ~sel16;
  assign v16    = in_valid & sel16;
  assign fl32   = flush & ~sel16;
  assign fl16   = flush & sel16;
  assign ordy32 = out_ready & ~sel16;
  assign ordy16 = out_ready & sel16;
  assign obs_ready  = sel16 ? rdy16 : rdy32;
  assign obs_valid  = sel16 ? ov16 : ov32;
  assign obs_result = sel16 ? {16'd0, res16} : res32;

  muldiv_unit #(.XLEN(32)) dut32 (
    .clk(clk), .reset(rst32), .in_valid(v32), .in_ready(rdy32), .in_func(in_func),
    .in_op1(in_op1), .in_op2(in_op2), .flush(fl32), .out_valid(ov32),
    .out_ready(ordy32), .out_result(res32)
  );

  muldiv_unit #(.XLEN(16)) dut16 (
    .clk(clk), .reset(rst16), .in_valid(v16), .in_ready(rdy16), .in_func(in_func),
    .in_op1(in_op1[15:0]), .in_op2(in_op2[15:0]), .flush(fl16), .out_valid(ov16),
    .out_ready(ordy16), .out_result(res16)
  );

  // Reference semantics written with 64-bit integer arithmetic.
  function automatic logic [31:0] ref_model(input logic [2:0] f, input logic [31:0] a,
                                            input logic [31:0] b, input int w);
    logic [63:0] mask, ua, ub, r;
    longint sa, sb, min_s;
    mask  = (64'd1 << w) - 64'd1;
    ua    = {32'd0, a} & mask;
    ub    = {32'd0, b} & mask;
    sa    = $signed(ua);
    sb    = $signed(ub);
    if (ua[w-1]) sa = sa - (longint'(1) <<< w);
    if (ub[w-1]) sb = sb - (longint'(1) <<< w);
    min_s = -(longint'(1) <<< (w - 1));
    r = '0;
    case (f)
      FUNC_MUL:    r = sa * sb;
      FUNC_MULH:   r = (sa * sb) >>> w;
      FUNC_MULHSU: r = (sa * $signed(ub)) >>> w;
      FUNC_MULHU:  r = (ua * ub) >> w;
      FUNC_DIV: begin
        if (ub == 0) r = mask;
        else if (sa == min_s && sb == -1) r = ua;
        else r = sa / sb;
      end
      FUNC_DIVU:   r = (ub == 0) ? mask : ua / ub;
      FUNC_REM: begin
        if (ub == 0) r = ua;
        else if (sa == min_s && sb == -1) r = '0;
        else r = sa % sb;
      end
      default:     r = (ub == 0) ? ua : ua % ub;
    endcase
    r = r & mask;
    return r[31:0];
  endfunction

  function automatic int exp_latency(input logic [2:0] f, input logic [31:0] a,
                                     input logic [31:0] b, input int w);
    logic [31:0] mask, min_v;
    mask  = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    min_v = 32'd1 << (w - 1);
    if (f[2] && (((b & mask) == 0) ||
                 (!f[0] && (a & mask) == min_v && (b & mask) == mask))) return 1;
    return w + 1;
  endfunction

  function automatic logic [31:0] pick();
    logic [31:0] mask, v;
    mask = (cur_w == 32) ? 32'hFFFF_FFFF : ((32'd1 << cur_w) - 32'd1);
    case ($urandom_range(0, 7))
      0:       v = '0;
      1:       v = 32'hFFFF_FFFF;
      2:       v = 32'd1 << (cur_w - 1);
      3:       v = 32'd1;
      4:       v = $urandom_range(0, 15);
      default: v = $urandom;
    endcase
    return v & mask;
  endfunction

  // Issues one op from a negedge, waits (bounded) for the result, holds it for
  // 'hold' cycles, then handshakes it. Returns at a negedge with the unit idle.
  task automatic do_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                       input int hold, output logic [31:0] res, output int lat,
                       output bit busy_ok, output bit stable_ok);
    int limit;
    limit     = 3 * cur_w + 10;
    busy_ok   = (obs_ready === 1'b1);
    stable_ok = 1'b1;
    res       = '0;
    lat       = 0;
    in_valid  = 1'b1;
    in_func   = f;
    in_op1    = a;
    in_op2    = b;
    out_ready = 1'b0;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_op1   = $urandom;
    in_op2   = $urandom;
    while (lat < limit) begin
      @(negedge clk);
      lat++;
      if (obs_ready !== 1'b0) busy_ok = 1'b0;
      if (obs_valid === 1'b1) break;
    end
    if (obs_valid !== 1'b1) begin
      lat = -1;
    end else begin
      res = obs_result;
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        if (obs_valid !== 1'b1 || obs_result !== res) stable_ok = 1'b0;
        if (obs_ready !== 1'b0) busy_ok = 1'b0;
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
    end
  endtask

  task automatic test_reset();
    reset_all = 1'b1;
    repeat (3) @(negedge clk);
    reset_all = 1'b0;
    total += 6;
    if (rdy32 !== 1'b1) begin bad++; $display("[TB] FAIL reset in_ready32: got %b want 1", rdy32); end
    if (ov32 !== 1'b0) begin bad++; $display("[TB] FAIL reset out_valid32: got %b want 0", ov32); end
    if (res32 !== 32'd0) begin bad++; $display("[TB] FAIL reset out_result32: got %h want 0", res32); end
    if (rdy16 !== 1'b1) begin bad++; $display("[TB] FAIL reset in_ready16: got %b want 1", rdy16); end
    if (ov16 !== 1'b0) begin bad++; $display("[TB] FAIL reset out_valid16: got %b want 0", ov16); end
    if (res16 !== 16'd0) begin bad++; $display("[TB] FAIL reset out_result16: got %h want 0", res16); end
  endtask

  task automatic test_directed();
    case_t tbl[$];
    logic [31:0] res;
    int lat, want_lat;
    bit busy_ok, stable_ok;
    if (cur_w == 32) begin
      tbl.push_back('{FUNC_MUL,    32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB});
      tbl.push_back('{FUNC_MULH,   32'h8000_0000,  32'h8000_0000, 32'h4000_0000});
      tbl.push_back('{FUNC_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE});
      tbl.push_back('{FUNC_MULHSU, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF});
      tbl.push_back('{FUNC_DIV,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD});
      tbl.push_back('{FUNC_REM,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF});
      tbl.push_back('{FUNC_DIVU,   32'd100,        32'd7,         32'd14});
      tbl.push_back('{FUNC_REMU,   32'd100,        32'd7,         32'd2});
      tbl.push_back('{FUNC_DIV,    32'd5,          32'd0,         32'hFFFF_FFFF});
      tbl.push_back('{FUNC_REMU,   32'd5,          32'd0,         32'd5});
      tbl.push_back('{FUNC_DIV,    32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000});
      tbl.push_back('{FUNC_REM,    32'h8000_0000,  32'hFFFF_FFFF, 32'd0});
    end else begin
      tbl.push_back('{FUNC_MUL,    32'h00FF, 32'h0101, 32'hFFFF});
      tbl.push_back('{FUNC_MUL,    32'd7,    32'hFFFD, 32'hFFEB});
      tbl.push_back('{FUNC_MULH,   32'h8000, 32'h8000, 32'h4000});
      tbl.push_back('{FUNC_MULHU,  32'hFFFF, 32'hFFFF, 32'hFFFE});
      tbl.push_back('{FUNC_MULHSU, 32'hFFFF, 32'hFFFF, 32'hFFFF});
      tbl.push_back('{FUNC_DIV,    32'hFFF9, 32'd2,    32'hFFFD});
      tbl.push_back('{FUNC_REM,    32'hFFF9, 32'd2,    32'hFFFF});
      tbl.push_back('{FUNC_DIVU,   32'd100,  32'd7,    32'd14});
      tbl.push_back('{FUNC_REMU,   32'd100,  32'd7,    32'd2});
      tbl.push_back('{FUNC_DIV,    32'd5,    32'd0,    32'hFFFF});
      tbl.push_back('{FUNC_REMU,   32'd5,    32'd0,    32'd5});
      tbl.push_back('{FUNC_DIV,    32'h8000, 32'hFFFF, 32'h8000});
      tbl.push_back('{FUNC_REM,    32'h8000, 32'hFFFF, 32'd0});
    end
    foreach (tbl[i]) begin
      want_lat = (tbl[i].f[2] && (tbl[i].b == 32'd0 || tbl[i].b == ((cur_w == 32) ?
                  32'hFFFF_FFFF : 32'hFFFF) && !tbl[i].f[0])) ? 1 : cur_w + 1;
      do_op(tbl[i].f, tbl[i].a, tbl[i].b, 0, res, lat, busy_ok, stable_ok);
      total += 3;
      if (res !== tbl[i].exp) begin
        bad++;
        $display("[TB] FAIL directed w=%0d #%0d result: got %h want %h", cur_w, i, res, tbl[i].exp);
      end
      if (lat !== want_lat) begin
        bad++;
        $display("[TB] FAIL directed w=%0d #%0d latency: got %0d want %0d", cur_w, i, lat, want_lat);
      end
      if (busy_ok !== 1'b1) begin
        bad++;
        $display("[TB] FAIL directed w=%0d #%0d in_ready: got busy_ok=%b want 1", cur_w, i, busy_ok);
      end
    end
  endtask

  task automatic test_random(input int n);
    logic [2:0]  f;
    logic [31:0] a, b, res, want;
    int lat, want_lat;
    bit busy_ok, stable_ok;
    for (int i = 0; i < n; i++) begin
      f        = 3'($urandom_range(0, 7));
      a        = pick();
      b        = pick();
      want     = ref_model(f, a, b, cur_w);
      want_lat = exp_latency(f, a, b, cur_w);
      do_op(f, a, b, 0, res, lat, busy_ok, stable_ok);
      total += 2;
      if (res !== want) begin
        bad++;
        $display("[TB] FAIL random w=%0d f=%0d a=%h b=%h result: got %h want %h", cur_w, f, a, b, res, want);
      end
      if (lat !== want_lat) begin
        bad++;
        $display("[TB] FAIL random w=%0d f=%0d latency: got %0d want %0d", cur_w, f, lat, want_lat);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] a, b, res, want;
    int lat;
    bit busy_ok, stable_ok;
    a    = pick();
    b    = pick();
    want = ref_model(FUNC_MULHU, a, b, cur_w);
    do_op(FUNC_MULHU, a, b, 5, res, lat, busy_ok, stable_ok);
    total += 3;
    if (res !== want) begin bad++; $display("[TB] FAIL backpressure w=%0d result: got %h want %h", cur_w, res, want); end
    if (stable_ok !== 1'b1) begin bad++; $display("[TB] FAIL backpressure w=%0d hold: got stable=%b want 1", cur_w, stable_ok); end
    if (busy_ok !== 1'b1) begin bad++; $display("[TB] FAIL backpressure w=%0d in_ready: got busy_ok=%b want 1", cur_w, busy_ok); end
    // Next op is presented in the very cycle after the out_ready handshake.
    do_op(FUNC_DIVU, 32'd100, 32'd7, 0, res, lat, busy_ok, stable_ok);
    total += 3;
    if (busy_ok !== 1'b1) begin bad++; $display("[TB] FAIL followup w=%0d accept: got busy_ok=%b want 1", cur_w, busy_ok); end
    if (lat !== cur_w + 1) begin bad++; $display("[TB] FAIL followup w=%0d latency: got %0d want %0d", cur_w, lat, cur_w + 1); end
    if (res !== 32'd14) begin bad++; $display("[TB] FAIL followup w=%0d result: got %h want 0000000e", cur_w, res); end
  endtask

  task automatic test_kill(input bit use_reset);
    string kind;
    bit seen;
    int n;
    kind = use_reset ? "reset" : "flush";
    // Kill in CALC at cycle 10 of a DIV.
    in_valid = 1'b1; in_func = FUNC_DIV; in_op1 = $urandom; in_op2 = 32'd3;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (10) @(negedge clk);
    if (use_reset) reset = 1'b1; else flush = 1'b1;
    @(negedge clk);
    reset = 1'b0; flush = 1'b0;
    total += 3;
    if (obs_ready !== 1'b1) begin bad++; $display("[TB] FAIL %s calc w=%0d in_ready: got %b want 1", kind, cur_w, obs_ready); end
    if (obs_valid !== 1'b0) begin bad++; $display("[TB] FAIL %s calc w=%0d out_valid: got %b want 0", kind, cur_w, obs_valid); end
    seen = 1'b0;
    repeat (cur_w + 5) begin
      @(negedge clk);
      if (obs_valid !== 1'b0) seen = 1'b1;
    end
    if (seen !== 1'b0) begin bad++; $display("[TB] FAIL %s calc w=%0d late out_valid: got %b want 0", kind, cur_w, seen); end
    // Kill together with in_valid in IDLE: no accept, for both a normal and a fast-path op.
    for (int k = 0; k < 2; k++) begin
      in_valid = 1'b1; in_func = FUNC_DIVU; in_op1 = $urandom; in_op2 = (k == 0) ? 32'd5 : 32'd0;
      if (use_reset) reset = 1'b1; else flush = 1'b1;
      @(negedge clk);
      in_valid = 1'b0; reset = 1'b0; flush = 1'b0;
      total += 2;
      if (obs_ready !== 1'b1) begin bad++; $display("[TB] FAIL %s idle w=%0d #%0d in_ready: got %b want 1", kind, cur_w, k, obs_ready); end
      if (obs_valid !== 1'b0) begin bad++; $display("[TB] FAIL %s idle w=%0d #%0d out_valid: got %b want 0", kind, cur_w, k, obs_valid); end
    end
    // Kill in DONE racing out_ready: result dropped.
    in_valid = 1'b1; in_func = FUNC_MUL; in_op1 = 32'd3; in_op2 = 32'd5;
    @(posedge clk);
    #1 in_valid = 1'b0;
    n = 0;
    while (n < 3 * cur_w && obs_valid !== 1'b1) begin
      @(negedge clk);
      n++;
    end
    total += 1;
    if (obs_valid !== 1'b1) begin bad++; $display("[TB] FAIL %s done w=%0d reach: got out_valid=%b want 1", kind, cur_w, obs_valid); end
    if (use_reset) reset = 1'b1; else flush = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    reset = 1'b0; flush = 1'b0; out_ready = 1'b0;
    total += 2;
    if (obs_valid !== 1'b0) begin bad++; $display("[TB] FAIL %s done w=%0d out_valid: got %b want 0", kind, cur_w, obs_valid); end
    if (obs_ready !== 1'b1) begin bad++; $display("[TB] FAIL %s done w=%0d in_ready: got %b want 1", kind, cur_w, obs_ready); end
    if (use_reset) begin
      total += 1;
      if (obs_result !== 32'd0) begin bad++; $display("[TB] FAIL reset done w=%0d out_result: got %h want 0", cur_w, obs_result); end
    end
  endtask

  initial begin
    reset_all = 1'b1; sel16 = 1'b0; in_valid = 1'b0; flush = 1'b0; reset = 1'b0;
    out_ready = 1'b0; in_func = '0; in_op1 = '0; in_op2 = '0;
    test_reset();
    for (int pass = 0; pass < 2; pass++) begin
      cur_w = (pass == 0) ? 32 : 16;
      sel16 = (pass == 1);
      $display("[TB] running XLEN=%0d", cur_w);
      test_directed();
      test_random(40);
      test_backpressure();
      test_kill(1'b0);
      test_kill(1'b1);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
